// File: rtl/audio_codec_pkg.sv
// Shared types and defaults for the audio codec capture path.
// Holds the capture FSM encoding and the default per-channel word width.
package audio_codec_pkg;

    localparam int AUDIO_DATA_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        SYNC,
        LEFT,
        RIGHT
    } capture_state_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Show-ahead synchronous FIFO with level, full and clear; head visible combinationally from registers.
// Write/read take effect on the next edge; a write while full is accepted only alongside a read.
module audio_sample_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       wr_vld,
    input  logic [DW-1:0]              wr_dat,
    output logic                       rd_vld,
    input  logic                       rd_rdy,
    output logic [DW-1:0]              rd_dat,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          rd_fire;
    logic          wr_fire;

    assign full    = (level == LW'(DEPTH));
    assign rd_vld  = (level != '0);
    assign rd_fire = rd_vld & rd_rdy;
    assign wr_fire = wr_vld & (~full | rd_fire);
    // Empty FIFO presents zeros rather than stale storage.
    assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_fire, rd_fire})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/audio_in_deserializer.sv
// I2S ADC capture: assembles MSB-first left/right words and queues stereo pairs for the bus side.
// Pair visible one cycle after the closing LRCK fall; a pair arriving at a full FIFO without a pop is dropped and flagged.
module audio_in_deserializer
    import audio_codec_pkg::*;
#(
    parameter int AUDIO_DATA_WIDTH = AUDIO_DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH       = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          bit_clk_rising_edge,
    input  logic                          left_right_clk_rising_edge,
    input  logic                          left_right_clk_falling_edge,
    input  logic                          counting,
    input  logic                          serial_audio_in_data,
    input  logic                          capture_enable,
    input  logic                          clear_fifo,
    input  logic                          clear_overflow,
    output logic [AUDIO_DATA_WIDTH-1:0]   out_left,
    output logic [AUDIO_DATA_WIDTH-1:0]   out_right,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int W  = AUDIO_DATA_WIDTH;
    localparam int IW = $clog2(W) + 1;
    localparam logic [W-1:0] MSB_BIT = W'(1) << (W - 1);

    capture_state_t state;
    logic [W-1:0]   shift_word;
    logic [W-1:0]   pending_left;
    logic [IW-1:0]  bit_idx;
    logic           lr_edge;
    logic           bit_take;
    logic           push_vld;
    logic           pop;
    logic           fifo_full;
    logic [2*W-1:0] head_dat;

    assign lr_edge  = left_right_clk_rising_edge | left_right_clk_falling_edge;
    // An LR edge wins over a coincident bit-clock edge, so that bit is never taken.
    assign bit_take = bit_clk_rising_edge & counting & ~lr_edge
                    & (state != SYNC) & (bit_idx < IW'(W));
    assign push_vld = capture_enable & (state == RIGHT) & left_right_clk_falling_edge;
    assign pop      = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= SYNC;
            shift_word   <= '0;
            bit_idx      <= '0;
            pending_left <= '0;
            overflow     <= 1'b0;
        end else begin
            if (lr_edge) begin
                shift_word <= '0;
                bit_idx    <= '0;
            end else if (bit_take) begin
                if (serial_audio_in_data) begin
                    shift_word <= shift_word | (MSB_BIT >> bit_idx);
                end
                bit_idx <= bit_idx + IW'(1);
            end

            if (!capture_enable) begin
                state        <= SYNC;
                pending_left <= '0;
            end else begin
                case (state)
                    SYNC: begin
                        if (left_right_clk_falling_edge) state <= LEFT;
                    end
                    LEFT: begin
                        if (left_right_clk_rising_edge) begin
                            pending_left <= shift_word;
                            state        <= RIGHT;
                        end
                    end
                    RIGHT: begin
                        if (lr_edge) state <= LEFT;
                    end
                    default: state <= SYNC;
                endcase
            end

            // A fresh drop outranks a same-cycle clear request.
            if (clear_overflow) begin
                overflow <= 1'b0;
            end
            if (push_vld && !clear_fifo && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    audio_sample_fifo #(
        .DW    (2 * W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear_fifo),
        .wr_vld (push_vld),
        .wr_dat ({pending_left, shift_word}),
        .rd_vld (out_valid),
        .rd_rdy (out_ready),
        .rd_dat (head_dat),
        .level  (fifo_level),
        .full   (fifo_full)
    );

    assign out_left  = head_dat[2*W-1:W];
    assign out_right = head_dat[W-1:0];

endmodule
